// File: rtl/fft2d_corner_turn_if.sv
`default_nettype none
// ============================================================================
// fft2d_corner_turn_if
//   Row-major input stream and transposed output stream of the corner turn.
//   Rev 1.0
// ============================================================================
interface fft2d_corner_turn_if #(
  parameter int DATA_W = 16
);
  logic [2*DATA_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic                s_tlast;
  logic [2*DATA_W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;
  logic                m_frame_last;

  // slave: the corner-turn block; master: the surrounding datapath
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_frame_last
  );
  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_frame_last
  );
endinterface
`default_nettype wire

// File: rtl/fft2d_corner_turn.sv
`default_nettype none
// ============================================================================
// fft2d_corner_turn
//   Ping-pong N x N corner-turn buffer with per-frame transpose/bypass.
//   Rev 1.0
// ============================================================================
module fft2d_corner_turn #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transpose_en,
  fft2d_corner_turn_if.slave       bus,
  output logic                     evt_tlast_unexpected,
  output logic                     evt_tlast_missing,
  output logic [1:0]               bank_full
);
  localparam int SW    = 2 * DATA_W;
  localparam int AW    = 2 * LOG2N;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bstate_t;
  typedef enum logic {R_IDLE, R_DRAIN} rstate_t;

  bstate_t         r_bst [2];
  logic            r_alive;
  logic            r_wr_bank;
  logic [AW-1:0]   r_wr_cnt;
  logic [1:0]      r_mode;
  rstate_t         r_rstate;
  logic            r_rd_bank;
  logic [AW-1:0]   r_rd_cnt;
  logic            r_out_bank;
  logic [SW-1:0]   r_mem [2*DEPTH];

  logic            w_wr_ok;
  logic            w_wr_fire;
  logic            w_wr_last;
  logic            w_row_end;
  logic            w_adv;
  logic            w_can_issue;
  logic            w_issue;
  logic            w_rd_start;
  logic            w_free;
  logic [LOG2N-1:0] w_line;
  logic [LOG2N-1:0] w_pos;
  logic [AW-1:0]   w_rd_addr;

  assign w_wr_ok      = (r_bst[r_wr_bank] == B_EMPTY) || (r_bst[r_wr_bank] == B_FILLING);
  assign bus.s_tready = r_alive & w_wr_ok;
  assign w_wr_fire    = bus.s_tvalid & bus.s_tready;
  assign w_wr_last    = &r_wr_cnt;
  assign w_row_end    = &r_wr_cnt[LOG2N-1:0];

  // A read may be issued straight from R_IDLE so frames stream without a bubble
  assign w_adv       = !bus.m_tvalid || bus.m_tready;
  assign w_can_issue = (r_rstate == R_DRAIN) || (r_bst[r_rd_bank] == B_FULL);
  assign w_issue     = w_adv & w_can_issue;
  assign w_rd_start  = w_issue & (r_rstate == R_IDLE);
  assign w_free      = bus.m_tvalid & bus.m_tready & bus.m_frame_last;

  assign w_line    = r_rd_cnt[AW-1:LOG2N];
  assign w_pos     = r_rd_cnt[LOG2N-1:0];
  assign w_rd_addr = r_mode[r_rd_bank] ? {w_pos, w_line} : r_rd_cnt;

  assign bank_full[0] = (r_bst[0] == B_FULL) || (r_bst[0] == B_DRAINING);
  assign bank_full[1] = (r_bst[1] == B_FULL) || (r_bst[1] == B_DRAINING);

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      r_mem[{r_wr_bank, r_wr_cnt}] <= bus.s_tdata;
    end
  end

  // Write and read only ever touch banks in disjoint states, so these never collide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bst[0] <= B_EMPTY;
      r_bst[1] <= B_EMPTY;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (w_wr_fire && (r_wr_bank == 1'(b))) begin
          r_bst[b] <= w_wr_last ? B_FULL : B_FILLING;
        end
        if (w_rd_start && (r_rd_bank == 1'(b))) begin
          r_bst[b] <= B_DRAINING;
        end
        if (w_free && (r_out_bank == 1'(b))) begin
          r_bst[b] <= B_EMPTY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alive              <= 1'b0;
      r_wr_bank            <= 1'b0;
      r_wr_cnt             <= '0;
      r_mode               <= '0;
      evt_tlast_unexpected <= 1'b0;
      evt_tlast_missing    <= 1'b0;
    end else begin
      r_alive              <= 1'b1;
      evt_tlast_unexpected <= w_wr_fire & bus.s_tlast & !w_row_end;
      evt_tlast_missing    <= w_wr_fire & !bus.s_tlast & w_row_end;
      if (w_wr_fire) begin
        if (r_wr_cnt == '0) begin
          r_mode[r_wr_bank] <= transpose_en;
        end
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rstate         <= R_IDLE;
      r_rd_bank        <= 1'b0;
      r_rd_cnt         <= '0;
      r_out_bank       <= 1'b0;
      bus.m_tdata      <= '0;
      bus.m_tvalid     <= 1'b0;
      bus.m_tlast      <= 1'b0;
      bus.m_frame_last <= 1'b0;
    end else if (w_adv) begin
      bus.m_tvalid <= w_issue;
      if (w_issue) begin
        bus.m_tdata      <= r_mem[{r_rd_bank, w_rd_addr}];
        bus.m_tlast      <= &w_pos;
        bus.m_frame_last <= &r_rd_cnt;
        r_out_bank       <= r_rd_bank;
        r_rd_cnt         <= r_rd_cnt + 1'b1;
        if (&r_rd_cnt) begin
          r_rstate  <= R_IDLE;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rstate  <= R_DRAIN;
        end
      end else begin
        bus.m_tlast      <= 1'b0;
        bus.m_frame_last <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fft2d_corner_turn.sv
`default_nettype none
// ============================================================================
// tb_fft2d_corner_turn
//   Directed frames against a queue model of the expected output order.
//   Rev 1.0
// ============================================================================
module tb_fft2d_corner_turn;
  localparam int DATA_W = 16;
  localparam int LOG2N  = 2;
  localparam int N      = 1 << LOG2N;
  localparam int DEPTH  = N * N;

  typedef struct {
    logic [31:0] d;
    logic        tl;
    logic        fl;
  } samp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       transpose_en = 1'b0;
  logic       evt_u;
  logic       evt_m;
  logic [1:0] bank_full;
  int         rdy_mode = 0;

  fft2d_corner_turn_if #(.DATA_W(DATA_W)) bus ();

  fft2d_corner_turn #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .clk                  (clk),
    .reset                (rst_n),
    .transpose_en         (transpose_en),
    .bus                  (bus),
    .evt_tlast_unexpected (evt_u),
    .evt_tlast_missing    (evt_m),
    .bank_full            (bank_full)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  int    n_u   = 0;
  int    n_m   = 0;
  samp_t exp_q[$];
  samp_t got_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  // Output order from the frame definition: output k reads input (k%N)*N + k/N when transposed
  task automatic push_model(input bit te, input logic [15:0] tag);
    for (int k = 0; k < DEPTH; k++) begin
      samp_t s;
      int src;
      src  = te ? ((k % N) * N + k / N) : k;
      s.d  = {tag, 16'(src)};
      s.tl = (k % N) == N - 1;
      s.fl = (k == DEPTH - 1);
      exp_q.push_back(s);
    end
  endtask

  initial begin
    bus.m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.m_tready = 1'b0;
        1:       bus.m_tready = 1'b1;
        default: bus.m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit    held = 0;
  samp_t held_s;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held) begin
        chk("stall valid held", bus.m_tvalid, 1);
        chk("stall data held", {bus.m_tdata, bus.m_tlast, bus.m_frame_last},
            {held_s.d, held_s.tl, held_s.fl});
      end
      if (bus.m_tvalid && bus.m_tready) begin
        samp_t g;
        g.d  = bus.m_tdata;
        g.tl = bus.m_tlast;
        g.fl = bus.m_frame_last;
        got_q.push_back(g);
        held = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected output", 1, 0);
        end else begin
          samp_t e;
          e = exp_q.pop_front();
          chk("output sample", {g.d, g.tl, g.fl}, {e.d, e.tl, e.fl});
        end
      end else if (bus.m_tvalid) begin
        held   = 1;
        held_s.d  = bus.m_tdata;
        held_s.tl = bus.m_tlast;
        held_s.fl = bus.m_frame_last;
      end else begin
        held = 0;
      end
      if (evt_u) n_u++;
      if (evt_m) n_m++;
    end
  end

  task automatic send_frame(input bit te, input logic [15:0] tag, input int cnt,
                            input int bad_u, input int bad_m, input int gap);
    if (cnt == DEPTH) push_model(te, tag);
    for (int i = 0; i < cnt; i++) begin
      bit rdy;
      int cyc;
      transpose_en = te;
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = {tag, 16'(i)};
      bus.s_tlast  = (i % N) == N - 1;
      if (i == bad_u) bus.s_tlast = 1'b1;
      if (i == bad_m) bus.s_tlast = 1'b0;
      cyc = 0;
      do begin
        @(negedge clk);
        rdy = bus.s_tready;
        @(posedge clk);
        #1;
        cyc++;
      end while (!rdy && cyc < 500);
      if (!rdy) begin
        chk("s_tready timeout", 0, 1);
        bus.s_tvalid = 1'b0;
        return;
      end
      if (gap > 0) begin
        bus.s_tvalid = 1'b0;
        repeat ($urandom_range(0, gap)) @(posedge clk);
        #0;
      end
    end
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({nm, " drained"}, 64'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " bank_full idle"}, 64'(bank_full), 0);
    chk({nm, " m_tvalid idle"}, 64'(bus.m_tvalid), 0);
    chk({nm, " s_tready idle"}, 64'(bus.s_tready), 1);
  endtask

  initial begin
    int lit_t [16];
    lit_t = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;

    #23;
    chk("reset s_tready", bus.s_tready, 0);
    chk("reset m_tvalid", bus.m_tvalid, 0);
    chk("reset m_tdata", bus.m_tdata, 0);
    chk("reset flags", {bus.m_tlast, bus.m_frame_last, evt_u, evt_m}, 0);
    chk("reset bank_full", bank_full, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Transposed frame, literal order and line markers
    rdy_mode = 1;
    got_q.delete();
    send_frame(1'b1, 16'h0000, DEPTH, -1, -1, 0);
    wait_drain("t1");
    chk("t1 count", got_q.size(), 16);
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      chk("t1 literal", {got_q[k].d, got_q[k].tl, got_q[k].fl},
          {16'h0, 16'(lit_t[k]), lit_t[k] >= 12, lit_t[k] == 15});
    end

    // Bypass frame
    got_q.delete();
    send_frame(1'b0, 16'h0000, DEPTH, -1, -1, 0);
    wait_drain("t2");
    for (int k = 0; k < 16 && k < got_q.size(); k++) begin
      chk("t2 literal", {got_q[k].d[15:0], got_q[k].tl},
          {16'(k), (k == 3) || (k == 7) || (k == 11) || (k == 15)});
    end

    // Both banks fill while output is blocked
    rdy_mode = 0;
    send_frame(1'b1, 16'h0100, DEPTH, -1, -1, 0);
    send_frame(1'b0, 16'h0200, DEPTH, -1, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3 s_tready low", bus.s_tready, 0);
    chk("t3 bank_full", bank_full, 2'b11);
    fork
      send_frame(1'b1, 16'h0300, DEPTH, -1, -1, 0);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("t3 still blocked", bus.s_tready, 0);
        rdy_mode = 1;
      end
    join
    wait_drain("t3");

    // Random backpressure, alternating mode, input gaps
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      send_frame(f[0] == 1'b0, 16'hA000 + 16'(f), DEPTH, -1, -1, 2);
    end
    wait_drain("t4");
    chk("no evt before t5", {32'(n_u), 32'(n_m)}, 0);

    // Framing errors
    n_u = 0;
    n_m = 0;
    rdy_mode = 1;
    send_frame(1'b1, 16'h0500, DEPTH, 2, 7, 0);
    wait_drain("t5");
    chk("t5 unexpected pulses", n_u, 1);
    chk("t5 missing pulses", n_m, 1);

    // Reset while frame 1 drains and frame 2 is partly written
    rdy_mode = 0;
    send_frame(1'b1, 16'h0600, DEPTH, -1, -1, 0);
    send_frame(1'b1, 16'h0700, 9, -1, -1, 0);
    rst_n = 1'b0;
    #1;
    chk("t6 m_tvalid", bus.m_tvalid, 0);
    chk("t6 m_tdata", bus.m_tdata, 0);
    chk("t6 flags", {bus.m_tlast, bus.m_frame_last}, 0);
    chk("t6 bank_full", bank_full, 0);
    chk("t6 s_tready", bus.s_tready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_mode = 1;
    got_q.delete();
    send_frame(1'b1, 16'h0800, DEPTH, -1, -1, 0);
    wait_drain("t6");
    chk("t6 count", got_q.size(), 16);
    if (got_q.size() > 0) chk("t6 first", got_q[0].d, 32'h0800_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, want finished");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/fft2d_corner_turn.md
Name: fft2d_corner_turn

Overview:
Ping-pong corner-turn buffer that sits between the row-FFT and the column-FFT cores in the 2D-FFT datapath. It accepts an N×N frame of complex samples in row-major order over an AXI-stream-style slave port and emits the same frame in column-major order (transposed) over a master port. It is generalised in frame size and sample width, supports a per-frame bypass (row-major) mode, applies full valid/ready backpressure, and reports framing errors. Two banks allow frame k+1 to be written while frame k is read.

Parameters:
DATA_W, 16, width of each real/imag component
LOG2N, 7, log2 of frame side; N = 2^LOG2N (default 128×128)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
transpose_en  in  1  1 = column-major output, 0 = row-major pass-through; captured per frame
s_tdata  in  2*DATA_W  input sample, [2*DATA_W-1:DATA_W] imag, [DATA_W-1:0] real
s_tvalid  in  1  input sample valid
s_tready  out  1  block can accept input
s_tlast  in  1  end-of-row marker from row FFT
m_tdata  out  2*DATA_W  output sample, same packing
m_tvalid  out  1  output sample valid
m_tready  in  1  downstream accepts output
m_tlast  out  1  last sample of each output line (column or row) of N samples
m_frame_last  out  1  last sample of the frame (N*N-th)
evt_tlast_unexpected  out  1  one-cycle pulse: s_tlast=1 on a non-row-end sample
evt_tlast_missing  out  1  one-cycle pulse: s_tlast=0 on a row-end sample
bank_full  out  2  bit b = bank b holds a complete, not-yet-drained frame

Behaviour:
- Reset (reset=0, async): both banks EMPTY, write/read bank pointers 0, write/read counters 0, s_tready=0 during reset, m_tvalid=0, m_tlast=0, m_frame_last=0, m_tdata=0, evt_* = 0, bank_full=0. Reset mid-frame discards all buffered data; no partial frame is output after release.
- Storage: 2 banks × N*N words of 2*DATA_W bits, synchronous read, 1-cycle read latency.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side: s_tready = 1 iff current write bank is EMPTY or FILLING. Transfer on s_tvalid & s_tready. On the first transfer of a frame (wr_cnt=0) capture transpose_en into the bank's mode bit; bank -> FILLING. Address = wr_cnt (row-major). wr_cnt wraps at N*N-1: bank -> FULL, bank_full bit set same edge, write pointer toggles. If the other bank is not EMPTY, s_tready drops the next cycle.
- Framing check on every transfer: row end = (wr_cnt mod N == N-1). s_tlast & !row_end -> evt_tlast_unexpected pulse next cycle; !s_tlast & row_end -> evt_tlast_missing pulse. Counters never resync to s_tlast; data is still written.
- Read FSM: R_IDLE, R_DRAIN. R_IDLE -> R_DRAIN when read bank is FULL (bank -> DRAINING). Read index rd_cnt 0..N*N-1; line = rd_cnt>>LOG2N, pos = rd_cnt mod N. Transpose mode: addr = pos*N + line; bypass: addr = rd_cnt.
- Output pipeline: RAM read issued when output register empty or being consumed (m_tready=1 or m_tvalid=0); no sample dropped or duplicated under arbitrary m_tready. m_tdata/m_tlast/m_frame_last held stable while m_tvalid & !m_tready.
- m_tlast = (pos == N-1); m_frame_last = (rd_cnt == N*N-1).
- Frame end: on acceptance of the m_frame_last sample, bank -> EMPTY, bank_full bit cleared, read pointer toggles, FSM -> R_IDLE (or straight to R_DRAIN next cycle if the other bank is FULL).
- Latency: last write of a frame at edge t -> first m_tvalid=1 no later than edge t+3. With m_tready held 1, output is back-to-back, one sample per cycle, including across frames.
- Simultaneous: a write completing a bank on the same edge the read frees the other bank keeps s_tready=1 without a bubble.

Test Plan:
- LOG2N=2, transpose_en=1, inputs real=0..15 imag=0, correct s_tlast, m_tready=1 -> output real 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15; m_tlast on 12,13,14,15; m_frame_last on 15 only; no evt pulses.
- Same frame with transpose_en=0 -> output 0..15 in order, m_tlast on 3,7,11,15.
- Three back-to-back frames, m_tready=0 throughout -> s_tready drops after sample 32 (both banks FULL), bank_full=2'b11; raise m_tready -> frame 1 then 2 then 3 intact.
- Random m_tready (50%) over 4 frames with alternating transpose_en -> every output matches model, no loss/duplication, stable data during stalls.
- s_tlast on sample 2 and absent on sample 7 -> evt_tlast_unexpected pulse once, evt_tlast_missing pulse once; output frame still correct.
- reset pulsed low at sample 9 of frame 2 while frame 1 drains -> all outputs 0 immediately, bank_full=0; next full frame output correctly from sample 0.
